// File: rtl/lc3_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lc3_mem_pkg
// Brief    : Shared types and defaults for the LC-3 memory arbiter slice.
// Revision : 1.0 - initial release
// ============================================================================
package lc3_mem_pkg;

    localparam int c_DEF_ADDR_W = 16;
    localparam int c_DEF_DATA_W = 16;

    typedef enum logic {
        PORT_CPU = 1'b0,
        PORT_DMA = 1'b1
    } port_e;

    typedef enum logic [0:0] {
        ARB_IDLE   = 1'b0,
        ARB_ACCESS = 1'b1
    } arb_state_e;

    // Round-robin pick; on a tie the port that did not win last time goes first.
    function automatic port_e rr_pick(input logic cpu_bid, input logic dma_bid, input port_e last);
        port_e winner;
        if (cpu_bid && dma_bid)
            winner = (last == PORT_DMA) ? PORT_CPU : PORT_DMA;
        else if (cpu_bid)
            winner = PORT_CPU;
        else
            winner = PORT_DMA;
        return winner;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lc3_mem_port_ctl.sv
`default_nettype none
// ============================================================================
// Module   : lc3_mem_port_ctl
// Brief    : One requester's done flag, re-arm/eligibility and read-data register.
// Revision : 1.0 - initial release
// ============================================================================
module lc3_mem_port_ctl #(
    parameter int DATA_W = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req,
    input  logic              complete,
    input  logic              load_rdata,
    input  logic [DATA_W-1:0] rdata_in,
    output logic              done,
    output logic              bid,
    output logic [DATA_W-1:0] rdata
);

    logic              r_done;
    logic [DATA_W-1:0] r_rdata;

    // done stays up until the request is seen low, which blocks a re-grant
    // while the requester still holds its level request.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_done  <= 1'b0;
            r_rdata <= '0;
        end else if (complete) begin
            r_done <= 1'b1;
            if (load_rdata)
                r_rdata <= rdata_in;
        end else if (r_done && !req) begin
            r_done <= 1'b0;
        end
    end

    assign done  = r_done;
    assign bid   = req & ~r_done;
    assign rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/lc3_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : lc3_mem_arbiter
// Brief    : Round-robin arbiter sharing LC-3 main memory between CPU and DMA.
// Revision : 1.0 - initial release
// ============================================================================
module lc3_mem_arbiter
    import lc3_mem_pkg::*;
#(
    parameter int ADDR_W  = c_DEF_ADDR_W,
    parameter int DATA_W  = c_DEF_DATA_W,
    parameter int MEM_LAT = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cpu_read,
    input  logic              cpu_write,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_done,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic [DATA_W-1:0] dma_rdata,
    output logic              dma_done,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              protocol_err
);

    localparam int         c_CNT_W     = $clog2(MEM_LAT + 1);
    localparam logic [0:0] c_ST_IDLE   = ARB_IDLE;
    localparam logic [0:0] c_ST_ACCESS = ARB_ACCESS;

    logic [0:0]         r_state;
    logic [c_CNT_W-1:0] r_cnt;
    port_e              r_last;
    port_e              r_owner;
    logic               r_mem_en;
    logic               r_mem_we;
    logic [ADDR_W-1:0]  r_mem_addr;
    logic [DATA_W-1:0]  r_mem_wdata;
    logic               r_perr;

    logic  w_cpu_req;
    logic  w_cpu_bid;
    logic  w_dma_bid;
    logic  w_finish;
    logic  w_cpu_complete;
    logic  w_dma_complete;
    port_e w_winner;

    assign w_cpu_req      = cpu_read | cpu_write;
    assign w_winner       = rr_pick(w_cpu_bid, w_dma_bid, r_last);
    assign w_finish       = (r_state == c_ST_ACCESS) && (r_cnt == '0);
    assign w_cpu_complete = w_finish && (r_owner == PORT_CPU);
    assign w_dma_complete = w_finish && (r_owner == PORT_DMA);

    lc3_mem_port_ctl #(
        .DATA_W (DATA_W)
    ) u_cpu_port (
        .clock      (clock),
        .reset      (reset),
        .req        (w_cpu_req),
        .complete   (w_cpu_complete),
        .load_rdata (~r_mem_we),
        .rdata_in   (mem_rdata),
        .done       (cpu_done),
        .bid        (w_cpu_bid),
        .rdata      (cpu_rdata)
    );

    lc3_mem_port_ctl #(
        .DATA_W (DATA_W)
    ) u_dma_port (
        .clock      (clock),
        .reset      (reset),
        .req        (dma_req),
        .complete   (w_dma_complete),
        .load_rdata (~r_mem_we),
        .rdata_in   (mem_rdata),
        .done       (dma_done),
        .bid        (w_dma_bid),
        .rdata      (dma_rdata)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= c_ST_IDLE;
            r_cnt       <= '0;
            r_last      <= PORT_DMA;
            r_owner     <= PORT_CPU;
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_perr      <= 1'b0;
        end else begin
            if (cpu_read && cpu_write)
                r_perr <= 1'b1;

            if (r_state == c_ST_IDLE) begin
                if (w_cpu_bid || w_dma_bid) begin
                    r_owner  <= w_winner;
                    r_last   <= w_winner;
                    r_mem_en <= 1'b1;
                    r_cnt    <= c_CNT_W'(MEM_LAT - 1);
                    r_state  <= c_ST_ACCESS;
                    // Write takes precedence when the CPU raises both strobes.
                    if (w_winner == PORT_CPU) begin
                        r_mem_we    <= cpu_write;
                        r_mem_addr  <= cpu_addr;
                        r_mem_wdata <= cpu_wdata;
                    end else begin
                        r_mem_we    <= dma_we;
                        r_mem_addr  <= dma_addr;
                        r_mem_wdata <= dma_wdata;
                    end
                end
            end else begin
                if (r_cnt == '0) begin
                    r_mem_en <= 1'b0;
                    r_mem_we <= 1'b0;
                    r_state  <= c_ST_IDLE;
                end else begin
                    r_cnt <= r_cnt - c_CNT_W'(1);
                end
            end
        end
    end

    assign mem_en       = r_mem_en;
    assign mem_we       = r_mem_we;
    assign mem_addr     = r_mem_addr;
    assign mem_wdata    = r_mem_wdata;
    assign busy         = r_mem_en;
    assign protocol_err = r_perr;

endmodule
`default_nettype wire

// File: tb/tb_lc3_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_lc3_mem_arbiter
// Brief    : Scoreboard bench for lc3_mem_arbiter (MEM_LAT=2 and MEM_LAT=1 instances).
// Revision : 1.0 - initial release
// ============================================================================
module tb_lc3_mem_arbiter;

    localparam bit P_CPU = 1'b0;
    localparam bit P_DMA = 1'b1;
    localparam logic [15:0] C_SW [8] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444,
                                         16'h5A5A, 16'hA5A5, 16'hC0DE, 16'hF00D};

    typedef struct packed {
        bit          port;
        bit          rd;
        logic [15:0] data;
    } exp_t;

    logic clock;
    logic reset;
    int   checks;
    int   failures;
    int   cyc;
    exp_t q_a[$];
    exp_t q_b[$];
    int   done_t_a[$];
    int   done_t_b[$];

    // Instance A: MEM_LAT = 2
    logic        cpu_read, cpu_write, cpu_done, dma_req, dma_we, dma_done;
    logic [15:0] cpu_addr, cpu_wdata, cpu_rdata, dma_addr, dma_wdata, dma_rdata;
    logic        mem_en, mem_we, busy, protocol_err;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;
    logic [15:0] ram_a [0:65535];

    // Instance B: MEM_LAT = 1
    logic        b_cpu_read, b_cpu_write, b_cpu_done, b_dma_req, b_dma_we, b_dma_done;
    logic [15:0] b_cpu_addr, b_cpu_wdata, b_cpu_rdata, b_dma_addr, b_dma_wdata, b_dma_rdata;
    logic        b_mem_en, b_mem_we, b_busy, b_protocol_err;
    logic [15:0] b_mem_addr, b_mem_wdata, b_mem_rdata;
    logic [15:0] ram_b [0:65535];

    lc3_mem_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(2)) dut (
        .clock(clock), .reset(reset),
        .cpu_read(cpu_read), .cpu_write(cpu_write), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_done(cpu_done),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_rdata(dma_rdata), .dma_done(dma_done),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy), .protocol_err(protocol_err)
    );

    lc3_mem_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(1)) dut_b (
        .clock(clock), .reset(reset),
        .cpu_read(b_cpu_read), .cpu_write(b_cpu_write), .cpu_addr(b_cpu_addr), .cpu_wdata(b_cpu_wdata),
        .cpu_rdata(b_cpu_rdata), .cpu_done(b_cpu_done),
        .dma_req(b_dma_req), .dma_we(b_dma_we), .dma_addr(b_dma_addr), .dma_wdata(b_dma_wdata),
        .dma_rdata(b_dma_rdata), .dma_done(b_dma_done),
        .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
        .mem_rdata(b_mem_rdata), .busy(b_busy), .protocol_err(b_protocol_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;
    initial begin
        cyc = 0;
        forever begin
            @(posedge clock);
            cyc++;
        end
    end

    // RAM models: combinational read, write on clock while enabled
    assign mem_rdata   = ram_a[mem_addr];
    assign b_mem_rdata = ram_b[b_mem_addr];
    always @(posedge clock) begin
        if (reset) begin
            ram_a[16'h3000] <= 16'h1234;
            for (int i = 0; i < 8; i++) ram_b[16'h0010 + 16'(i)] <= C_SW[i];
        end else begin
            if (mem_en && mem_we) ram_a[mem_addr] <= mem_wdata;
            if (b_mem_en && b_mem_we) ram_b[b_mem_addr] <= b_mem_wdata;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        failures++;
        $display("FAIL %s: got timeout/unexpected event expected a clean handshake", name);
    endtask

    task automatic push_a(input bit port, input bit rd, input logic [15:0] d);
        q_a.push_back({port, rd, d});
    endtask

    task automatic sb_check(input bit which, input bit port, input logic [15:0] rd);
        exp_t e;
        if (which == 1'b0) begin
            if (q_a.size() == 0) begin fail("a_unexpected_done"); return; end
            e = q_a.pop_front();
            done_t_a.push_back(cyc);
            chk("a_sb_port", 32'(port), 32'(e.port));
            if (e.rd) chk("a_sb_rdata", 32'(rd), 32'(e.data));
        end else begin
            if (q_b.size() == 0) begin fail("b_unexpected_done"); return; end
            e = q_b.pop_front();
            done_t_b.push_back(cyc);
            chk("b_sb_port", 32'(port), 32'(e.port));
            if (e.rd) chk("b_sb_rdata", 32'(rd), 32'(e.data));
        end
    endtask

    // Monitors: detect done rising edges and access lengths
    initial begin
        bit pc, pd, pen, bpc, bpd, bpen;
        int run, brun;
        pc = 0; pd = 0; pen = 0; bpc = 0; bpd = 0; bpen = 0; run = 0; brun = 0;
        forever begin
            @(negedge clock);
            if (reset) begin
                run = 0;
                brun = 0;
            end else begin
                if (cpu_done && !pc) sb_check(1'b0, P_CPU, cpu_rdata);
                if (dma_done && !pd) sb_check(1'b0, P_DMA, dma_rdata);
                if (b_cpu_done && !bpc) sb_check(1'b1, P_CPU, b_cpu_rdata);
                if (b_dma_done && !bpd) sb_check(1'b1, P_DMA, b_dma_rdata);
                if (mem_en) run++;
                else if (pen) begin chk("a_mem_en_len", 32'(run), 32'd2); run = 0; end
                if (b_mem_en) brun++;
                else if (bpen) begin chk("b_mem_en_len", 32'(brun), 32'd1); brun = 0; end
            end
            pc = cpu_done; pd = dma_done; pen = mem_en;
            bpc = b_cpu_done; bpd = b_dma_done; bpen = b_mem_en;
        end
    end

    function automatic bit a_done(input bit port);
        return (port == P_CPU) ? cpu_done : dma_done;
    endfunction

    function automatic bit b_done(input bit port);
        return (port == P_CPU) ? b_cpu_done : b_dma_done;
    endfunction

    task automatic a_go(input bit port, input bit rd, input bit wr, input logic [15:0] a, input logic [15:0] d);
        int n;
        @(posedge clock); #1;
        if (port == P_CPU) begin cpu_addr = a; cpu_wdata = d; cpu_read = rd; cpu_write = wr; end
        else begin dma_addr = a; dma_wdata = d; dma_we = wr; dma_req = 1'b1; end
        n = 0;
        while (!a_done(port) && n < 40) begin @(posedge clock); #1; n++; end
        if (!a_done(port)) fail("a_done_timeout");
        if (port == P_CPU) begin cpu_read = 1'b0; cpu_write = 1'b0; end
        else dma_req = 1'b0;
        n = 0;
        while (a_done(port) && n < 5) begin @(posedge clock); #1; n++; end
        if (a_done(port)) fail("a_done_release");
    endtask

    task automatic b_go(input bit port, input logic [15:0] a);
        int n;
        @(posedge clock); #1;
        if (port == P_CPU) begin b_cpu_addr = a; b_cpu_read = 1'b1; end
        else begin b_dma_addr = a; b_dma_req = 1'b1; end
        n = 0;
        while (!b_done(port) && n < 40) begin @(posedge clock); #1; n++; end
        if (!b_done(port)) fail("b_done_timeout");
        if (port == P_CPU) b_cpu_read = 1'b0; else b_dma_req = 1'b0;
        n = 0;
        while (b_done(port) && n < 5) begin @(posedge clock); #1; n++; end
        if (b_done(port)) fail("b_done_release");
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got simulation still running expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        checks = 0; failures = 0; reset = 1'b1;
        cpu_read = 0; cpu_write = 0; cpu_addr = 0; cpu_wdata = 0;
        dma_req = 0; dma_we = 0; dma_addr = 0; dma_wdata = 0;
        b_cpu_read = 0; b_cpu_write = 0; b_cpu_addr = 0; b_cpu_wdata = 0;
        b_dma_req = 0; b_dma_we = 0; b_dma_addr = 0; b_dma_wdata = 0;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;

        // Reset state
        chk("rst_ctrl", {26'd0, mem_en, mem_we, busy, cpu_done, dma_done, protocol_err}, 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_rdata", {cpu_rdata, dma_rdata}, 32'd0);

        // Single CPU read with a long-held request
        @(posedge clock); #1;
        cpu_read = 1'b1; cpu_addr = 16'h3000;
        push_a(P_CPU, 1'b1, 16'h1234);
        @(posedge clock); #1;
        chk("t1_e0_en", {30'd0, mem_en, busy}, 32'd3);
        chk("t1_e0_we", 32'(mem_we), 32'd0);
        chk("t1_e0_addr", 32'(mem_addr), 32'h3000);
        chk("t1_e0_done", 32'(cpu_done), 32'd0);
        @(posedge clock); #1;
        chk("t1_e1_en", 32'(mem_en), 32'd1);
        chk("t1_e1_done", 32'(cpu_done), 32'd0);
        @(posedge clock); #1;
        chk("t1_e2_done", 32'(cpu_done), 32'd1);
        chk("t1_e2_rdata", 32'(cpu_rdata), 32'h1234);
        chk("t1_e2_en", 32'(mem_en), 32'd0);
        repeat (3) begin
            @(posedge clock); #1;
            chk("t1_hold_no_access", 32'(mem_en), 32'd0);
            chk("t1_hold_done", 32'(cpu_done), 32'd1);
        end
        cpu_read = 1'b0;
        @(posedge clock); #1;
        chk("t1_done_fall", 32'(cpu_done), 32'd0);

        // Simultaneous pair after reset: CPU first, DMA one IDLE cycle later
        do_reset();
        done_t_a.delete();
        push_a(P_CPU, 1'b1, 16'h1234);
        push_a(P_DMA, 1'b0, 16'h0000);
        fork
            a_go(P_CPU, 1'b1, 1'b0, 16'h3000, 16'h0000);
            a_go(P_DMA, 1'b1, 1'b1, 16'h4000, 16'hBEEF);
        join
        repeat (2) @(posedge clock);
        if (done_t_a.size() == 2) chk("t2_gap", 32'(done_t_a[1] - done_t_a[0]), 32'd3);
        else chk("t2_done_count", 32'(done_t_a.size()), 32'd2);

        // DMA write then CPU read of the same word
        push_a(P_DMA, 1'b0, 16'h0000);
        a_go(P_DMA, 1'b1, 1'b1, 16'h3001, 16'h0FF0);
        push_a(P_CPU, 1'b1, 16'h0FF0);
        a_go(P_CPU, 1'b1, 1'b0, 16'h3001, 16'h0000);

        // Repeat simultaneous pair: last grant was CPU, so DMA goes first
        push_a(P_DMA, 1'b1, 16'h0FF0);
        push_a(P_CPU, 1'b1, 16'hBEEF);
        fork
            a_go(P_CPU, 1'b1, 1'b0, 16'h4000, 16'h0000);
            a_go(P_DMA, 1'b1, 1'b0, 16'h3001, 16'h0000);
        join

        // Read and write together: write wins, error is sticky
        push_a(P_CPU, 1'b0, 16'h0000);
        a_go(P_CPU, 1'b1, 1'b1, 16'h3002, 16'h5555);
        chk("t4_perr_set", 32'(protocol_err), 32'd1);
        push_a(P_DMA, 1'b1, 16'h5555);
        a_go(P_DMA, 1'b1, 1'b0, 16'h3002, 16'h0000);
        repeat (3) @(posedge clock);
        #1 chk("t4_perr_sticky", 32'(protocol_err), 32'd1);

        // Reset in the middle of an access
        @(posedge clock); #1;
        cpu_read = 1'b1; cpu_addr = 16'h3000;
        @(posedge clock); #1;
        chk("t5_pre_en", 32'(mem_en), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("t5_rst_ctrl", {26'd0, mem_en, mem_we, busy, cpu_done, dma_done, protocol_err}, 32'd0);
        chk("t5_rst_mem", {mem_addr, mem_wdata}, 32'd0);
        chk("t5_rst_rdata", {cpu_rdata, dma_rdata}, 32'd0);
        cpu_read = 1'b0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        repeat (4) @(posedge clock);
        #1 chk("t5_no_done", {30'd0, cpu_done, mem_en}, 32'd0);
        push_a(P_CPU, 1'b1, 16'h1234);
        push_a(P_DMA, 1'b1, 16'hBEEF);
        fork
            a_go(P_CPU, 1'b1, 1'b0, 16'h3000, 16'h0000);
            a_go(P_DMA, 1'b1, 1'b0, 16'h4000, 16'h0000);
        join

        // MEM_LAT=1 sweep: both ports hammer, accesses must alternate every 2 cycles
        done_t_b.delete();
        for (int i = 0; i < 8; i++) q_b.push_back({(i % 2 == 1) ? P_DMA : P_CPU, 1'b1, C_SW[i]});
        fork
            begin for (int k = 0; k < 4; k++) b_go(P_CPU, 16'h0010 + 16'(2 * k)); end
            begin for (int j = 0; j < 4; j++) b_go(P_DMA, 16'h0011 + 16'(2 * j)); end
        join
        repeat (2) @(posedge clock);
        if (done_t_b.size() == 8) begin
            for (int k = 1; k < 8; k++) chk("t6_interval", 32'(done_t_b[k] - done_t_b[k-1]), 32'd2);
        end else begin
            chk("t6_done_count", 32'(done_t_b.size()), 32'd8);
        end

        chk("a_sb_empty", 32'(q_a.size()), 32'd0);
        chk("b_sb_empty", 32'(q_b.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
